// File: rtl/fetch_pkg.sv
// Shared widths, reset vector and queue entry types for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            kill;
  } inflight_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of pc control, redirect, instruction-memory and decode handshake signals around fetch.
interface fetch_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] overwrite_pc;
  logic            overwrite_valid;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    input  pc, redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    output overwrite_pc, overwrite_valid, imem_req_valid, imem_req_addr,
           out_valid, out_pc, out_instr
  );

  modport slave (
    output pc, redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    input  overwrite_pc, overwrite_valid, imem_req_valid, imem_req_addr,
           out_valid, out_pc, out_instr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and a kill-all that marks every stored entry as stale.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   kill_all,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   head_kill,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] kill_r;
  logic [DEPTH-1:0] kill_nxt_s;
  logic [DEPTH-1:0] wr_mask_s;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Handshake qualification; a push into a full queue is legal only alongside a pop.
  always_comb begin
    pop_ok_s   = pop && (count_r != '0);
    push_ok_s  = push && ((count_r != FULL_CNT) || pop_ok_s);
    wr_mask_s  = push_ok_s ? (DEPTH'(1) << wr_ptr_r) : '0;
    kill_nxt_s = (kill_all ? {DEPTH{1'b1}} : kill_r) & ~wr_mask_s;
  end

  // Pointer, occupancy and kill-bit state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      kill_r   <= '0;
    end else begin
      rd_ptr_r <= pop_ok_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
      wr_ptr_r <= push_ok_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      kill_r   <= kill_nxt_s;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign head_kill = kill_r[rd_ptr_r];
  assign empty     = (count_r == '0);
  assign count     = count_r;

endmodule

// File: rtl/fetch_stage_chk.sv
// Protocol checks for the fetch stage: in-order responses need an outstanding request.
module fetch_stage_chk (
  input logic clk,
  input logic rst,
  input logic rsp_valid,
  input logic infl_empty,
  input logic out_valid,
  input logic out_head_kill
);

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    rsp_valid |-> !infl_empty);

  a_no_stale_to_decode: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> !out_head_kill);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: credit-limited issue, pc hold/redirect, stale-response squash, decode queue.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [CW-1:0]   infl_count_s;
  logic [CW-1:0]   out_count_s;
  logic [CW:0]     credit_sum_s;
  logic            can_issue_s;
  logic            req_valid_s;
  logic            accept_s;
  logic            ov_valid_s;
  logic [XLEN-1:0] ov_pc_s;
  logic            infl_empty_s;
  logic            infl_head_kill_s;
  logic [XLEN-1:0] infl_head_pc_s;
  inflight_entry_t infl_head_s;
  logic            out_empty_s;
  logic            out_head_kill_s;
  logic            out_push_s;
  logic            out_valid_s;
  logic            out_pop_s;
  fetch_entry_t    out_push_data_s;
  fetch_entry_t    out_head_s;

  // Credit covers both outstanding (even killed) requests and buffered instructions.
  always_comb begin
    credit_sum_s = {1'b0, infl_count_s} + {1'b0, out_count_s};
    can_issue_s  = !bus.redirect_valid && (credit_sum_s < DEPTH_C);
    req_valid_s  = can_issue_s && !rst;
    accept_s     = req_valid_s && bus.imem_req_ready;
  end

  // program_counter control: redirect wins, otherwise replay pc unless the fetch went out.
  always_comb begin
    ov_valid_s = 1'b0;
    ov_pc_s    = bus.pc;
    if (rst) begin
      ov_valid_s = 1'b0;
    end else if (bus.redirect_valid) begin
      ov_valid_s = 1'b1;
      ov_pc_s    = align_word(bus.redirect_pc);
    end else if (accept_s) begin
      ov_valid_s = 1'b0;
    end else begin
      ov_valid_s = 1'b1;
    end
  end

  // Response pairing and decode handshake; a redirect squashes everything in that cycle.
  always_comb begin
    infl_head_s     = '{pc: infl_head_pc_s, kill: infl_head_kill_s};
    out_push_s      = bus.imem_rsp_valid && !infl_empty_s && !infl_head_s.kill &&
                      !bus.redirect_valid && !rst;
    out_push_data_s = '{pc: infl_head_s.pc, instr: bus.imem_rsp_data};
    out_valid_s     = !out_empty_s && !bus.redirect_valid && !rst;
    out_pop_s       = out_valid_s && bus.out_ready;
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .kill_all  (bus.redirect_valid),
    .push      (accept_s),
    .push_data (bus.pc),
    .pop       (bus.imem_rsp_valid),
    .head_data (infl_head_pc_s),
    .head_kill (infl_head_kill_s),
    .empty     (infl_empty_s),
    .count     (infl_count_s)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_outq (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .kill_all  (1'b0),
    .push      (out_push_s),
    .push_data (out_push_data_s),
    .pop       (out_pop_s),
    .head_data (out_head_s),
    .head_kill (out_head_kill_s),
    .empty     (out_empty_s),
    .count     (out_count_s)
  );

  fetch_stage_chk u_chk (
    .clk           (clk),
    .rst           (rst),
    .rsp_valid     (bus.imem_rsp_valid),
    .infl_empty    (infl_empty_s),
    .out_valid     (out_valid_s),
    .out_head_kill (out_head_kill_s)
  );

  assign bus.imem_req_valid  = req_valid_s;
  assign bus.imem_req_addr   = bus.pc;
  assign bus.overwrite_valid = ov_valid_s;
  assign bus.overwrite_pc    = ov_pc_s;
  assign bus.out_valid       = out_valid_s;
  assign bus.out_pc          = out_head_s.pc;
  assign bus.out_instr       = out_head_s.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a program_counter model and an in-order memory model.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic mem_hold;
  int   tests = 0;
  int   fails = 0;

  fetch_if bus ();

  fetch_stage #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // program_counter model: reload on overwrite, otherwise advance by one word.
  always @(posedge clk) begin
    if (rst) bus.pc <= RESET_VECTOR;
    else if (bus.overwrite_valid) bus.pc <= bus.overwrite_pc;
    else bus.pc <= bus.pc + 32'd4;
  end

  // Memory model: in-order, at least one cycle of latency, responses can be held back.
  logic [31:0] mem_q [16];
  int mem_wr, mem_rd, req_count, pop_count;
  always @(posedge clk) begin
    if (rst) begin
      mem_wr <= 0; mem_rd <= 0; req_count <= 0; pop_count <= 0;
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        mem_q[mem_wr % 16] <= bus.imem_req_addr;
        mem_wr    <= mem_wr + 1;
        req_count <= req_count + 1;
      end
      if (bus.imem_rsp_valid) mem_rd <= mem_rd + 1;
      if (bus.out_valid && bus.out_ready) pop_count <= pop_count + 1;
    end
  end
  assign bus.imem_rsp_valid = (mem_wr != mem_rd) && !mem_hold && !rst;
  assign bus.imem_rsp_data  = instr_of(mem_q[mem_rd % 16]);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] epc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        seen = 1'b1;
        chk({tag, "_pc"}, bus.out_pc, epc);
        chk({tag, "_instr"}, bus.out_instr, instr_of(epc));
      end
      @(negedge clk);
    end
    if (!seen) chk({tag, "_timeout"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_outstanding(input string tag, input int n);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (mem_wr - mem_rd == n) ok = 1'b1;
      else @(negedge clk);
    end
    chk(tag, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_hold = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_ov_valid", {31'b0, bus.overwrite_valid}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Streaming from reset: decode sees 0x0, 0x4, 0x8 on consecutive cycles.
    rst = 1'b0;
    #1;
    chk("n0_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("n0_req_addr", bus.imem_req_addr, 32'h0);
    chk("n0_ov_valid", {31'b0, bus.overwrite_valid}, 32'd0);
    next_cyc();
    chk("n1_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("n1_pc", bus.pc, 32'h4);
    next_cyc();
    chk("n2_out_pc", bus.out_pc, 32'h0);
    chk("n2_out_instr", bus.out_instr, instr_of(32'h0));
    next_cyc();
    chk("n3_out_pc", bus.out_pc, 32'h4);
    next_cyc();
    chk("n4_out_pc", bus.out_pc, 32'h8);

    // Memory not ready for 3 cycles at pc 0x10: pc is replayed.
    bus.imem_req_ready = 1'b0;
    #1;
    chk("hold0_ov_valid", {31'b0, bus.overwrite_valid}, 32'd1);
    chk("hold0_ov_pc", bus.overwrite_pc, 32'h10);
    next_cyc();
    chk("n5_out_pc", bus.out_pc, 32'hC);
    chk("hold1_ov_valid", {31'b0, bus.overwrite_valid}, 32'd1);
    chk("hold1_ov_pc", bus.overwrite_pc, 32'h10);
    next_cyc();
    chk("n6_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("hold2_ov_valid", {31'b0, bus.overwrite_valid}, 32'd1);
    chk("hold2_pc", bus.pc, 32'h10);
    next_cyc();
    bus.imem_req_ready = 1'b1;
    #1;
    chk("rel_ov_valid", {31'b0, bus.overwrite_valid}, 32'd0);
    chk("rel_req_addr", bus.imem_req_addr, 32'h10);
    next_cyc();
    chk("n8_out_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cyc();
    chk("n9_out_pc", bus.out_pc, 32'h10);
    next_cyc();
    chk("n10_out_pc", bus.out_pc, 32'h14);

    // Decode stalls: credit allows exactly DEPTH outstanding plus buffered entries.
    bus.out_ready = 1'b0;
    next_cyc();
    next_cyc();
    chk("full_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("full_ov_pc", bus.overwrite_pc, 32'h24);
    next_cyc();
    chk("full2_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("full2_pc", bus.pc, 32'h24);
    chk("full_held", req_count - pop_count, 32'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) expect_out("resume", 32'h14 + 32'(4 * i));

    // Redirect with 3 requests in flight; stale responses must be dropped.
    mem_hold = 1'b1;
    wait_outstanding("wait3", 3);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203;
    #1;
    chk("redir_ov_valid", {31'b0, bus.overwrite_valid}, 32'd1);
    chk("redir_ov_pc", bus.overwrite_pc, 32'h200);
    chk("redir_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("redir_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b0; mem_hold = 1'b0;
    #1;
    chk("redir_pc", bus.pc, 32'h200);
    expect_out("redir_first", 32'h200);
    expect_out("redir_next", 32'h204);

    // Redirect coincident with a response and a ready decode.
    next_cyc();
    next_cyc();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300;
    #1;
    chk("coinc_rsp_valid", {31'b0, bus.imem_rsp_valid}, 32'd1);
    chk("coinc_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("coinc_ov_pc", bus.overwrite_pc, 32'h300);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    chk("coinc_after_out_valid", {31'b0, bus.out_valid}, 32'd0);
    expect_out("coinc_first", 32'h300);

    // Back-to-back redirects: the later target wins.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h500;
    @(negedge clk);
    bus.redirect_pc = 32'h601;
    #1;
    chk("b2b_ov_pc", bus.overwrite_pc, 32'h600);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    expect_out("b2b_first", 32'h600);

    // Address wrap at the top of the address space.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    expect_out("wrap_top", 32'hFFFF_FFFC);
    expect_out("wrap_zero", 32'h0);

    // Reset mid-stream with 2 requests in flight.
    mem_hold = 1'b1;
    wait_outstanding("wait2", 2);
    rst = 1'b1;
    #1;
    chk("mrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("mrst_ov_valid", {31'b0, bus.overwrite_valid}, 32'd0);
    next_cyc();
    chk("mrst2_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("mrst2_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mrst2_ov_valid", {31'b0, bus.overwrite_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_hold = 1'b0;
    expect_out("mrst_first", RESET_VECTOR);
    expect_out("mrst_next", RESET_VECTOR + 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
